// File: rtl/fix_tokenizer.sv
// fix_tokenizer
// Byte-level front end of the FIX receive path. Splits the raw ASCII stream
// of `<tag>=<value><SOH>` fields into tag/value tokens, marks message
// boundaries and verifies the CheckSum (tag 10) field.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   byte_valid_i/byte_i input byte stream, accepted when byte_ready_o is high
//   byte_ready_o        low only while a token pulse is being driven
//   tag_valid_o/tag_o   one-cycle tag token, binary tag number
//   val_valid_o/val_o   one-cycle value token, bytes right-justified
//   start_of_message_o  with tag_valid_o on the first tag of a message
//   end_of_message_o    with tag_valid_o when the tag is 10
//   checksum_valid_o    level, set when the received CheckSum matched
//   parse_error_o       one-cycle pulse on a syntax error
`ifndef VALUE_DATA_WIDTH
`define VALUE_DATA_WIDTH 64
`endif

module fix_tokenizer #(
    parameter int VALUE_WIDTH    = `VALUE_DATA_WIDTH,
    parameter int MAX_TAG_DIGITS = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   byte_valid_i,
    input  logic [7:0]             byte_i,
    output logic                   byte_ready_o,
    output logic                   tag_valid_o,
    output logic [31:0]            tag_o,
    output logic                   val_valid_o,
    output logic [VALUE_WIDTH-1:0] val_o,
    output logic                   start_of_message_o,
    output logic                   end_of_message_o,
    output logic                   checksum_valid_o,
    output logic                   parse_error_o
);

    localparam int         CNT_W = $clog2(MAX_TAG_DIGITS + 1);
    localparam logic [7:0] SOH   = 8'h01;
    localparam logic [7:0] EQ    = 8'h3D;

    typedef enum logic [1:0] {S_TAG, S_VAL, S_RESYNC} state_t;

    state_t state, state_nxt;

    logic [31:0]            tag_acc;
    logic [CNT_W-1:0]       digit_cnt;
    logic [VALUE_WIDTH-1:0] val_acc;
    logic                   first_tag;
    logic [7:0]             run_sum;
    logic [7:0]             tag_start_sum;
    logic [7:0]             cs_expected;
    logic                   in_cs;
    logic [9:0]             rx_cs;
    logic [2:0]             cs_digits;
    logic                   cs_bad;

    logic       take;
    logic       is_digit;
    logic       is_eq;
    logic       is_soh;
    logic [3:0] digit;
    logic       tag_done;
    logic       val_done;
    logic       err;
    logic       tag_digit;
    logic       val_byte;

    // A token pulse blocks intake for that one cycle, so a second token can
    // never be completed back-to-back with the first.
    assign byte_ready_o = !(tag_valid_o || val_valid_o);
    assign take         = byte_valid_i && byte_ready_o;
    assign is_digit     = (byte_i >= 8'h30) && (byte_i <= 8'h39);
    assign is_eq        = (byte_i == EQ);
    assign is_soh       = (byte_i == SOH);
    assign digit        = byte_i[3:0];

    always_ff @(posedge clk) begin
        if (rst) state <= S_TAG;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tag_done  = 1'b0;
        val_done  = 1'b0;
        err       = 1'b0;
        tag_digit = 1'b0;
        val_byte  = 1'b0;
        if (take) begin
            case (state)
                S_TAG: begin
                    if (is_digit && digit_cnt != CNT_W'(MAX_TAG_DIGITS)) begin
                        tag_digit = 1'b1;
                    end else if (is_eq && digit_cnt != '0) begin
                        tag_done  = 1'b1;
                        state_nxt = S_VAL;
                    end else begin
                        err       = 1'b1;
                        state_nxt = S_RESYNC;
                    end
                end
                S_VAL: begin
                    if (is_soh) begin
                        val_done  = 1'b1;
                        state_nxt = S_TAG;
                    end else begin
                        val_byte = 1'b1;
                    end
                end
                S_RESYNC: begin
                    if (is_soh) state_nxt = S_TAG;
                end
                default: state_nxt = S_TAG;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_valid_o        <= 1'b0;
            tag_o              <= '0;
            val_valid_o        <= 1'b0;
            val_o              <= '0;
            start_of_message_o <= 1'b0;
            end_of_message_o   <= 1'b0;
            checksum_valid_o   <= 1'b0;
            parse_error_o      <= 1'b0;
            tag_acc            <= '0;
            digit_cnt          <= '0;
            val_acc            <= '0;
            first_tag          <= 1'b1;
            run_sum            <= '0;
            tag_start_sum      <= '0;
            cs_expected        <= '0;
            in_cs              <= 1'b0;
            rx_cs              <= '0;
            cs_digits          <= '0;
            cs_bad             <= 1'b0;
        end else begin
            tag_valid_o        <= tag_done;
            val_valid_o        <= val_done;
            parse_error_o      <= err;
            start_of_message_o <= 1'b0;
            end_of_message_o   <= 1'b0;

            // The sum covers every accepted byte; bytes dropped while
            // resynchronising do not belong to any message.
            if (take && state != S_RESYNC) run_sum <= run_sum + byte_i;

            if (tag_digit) begin
                if (digit_cnt == '0) tag_start_sum <= run_sum;
                tag_acc   <= tag_acc * 32'd10 + {28'd0, digit};
                digit_cnt <= digit_cnt + 1'b1;
            end

            if (tag_done) begin
                tag_o              <= tag_acc;
                start_of_message_o <= first_tag;
                end_of_message_o   <= (tag_acc == 32'd10);
                if (first_tag) checksum_valid_o <= 1'b0;
                first_tag   <= 1'b0;
                in_cs       <= (tag_acc == 32'd10);
                cs_expected <= tag_start_sum;
                rx_cs       <= '0;
                cs_digits   <= '0;
                cs_bad      <= 1'b0;
                tag_acc     <= '0;
                digit_cnt   <= '0;
            end

            if (val_byte) begin
                val_acc <= {val_acc[VALUE_WIDTH-9:0], byte_i};
                if (in_cs) begin
                    if (is_digit) begin
                        rx_cs <= rx_cs * 10'd10 + {6'd0, digit};
                        if (cs_digits != 3'd7) cs_digits <= cs_digits + 3'd1;
                    end else begin
                        cs_bad <= 1'b1;
                    end
                end
            end

            if (val_done) begin
                val_o   <= val_acc;
                val_acc <= '0;
                if (in_cs) begin
                    checksum_valid_o <= !cs_bad && (cs_digits == 3'd3) &&
                                        (rx_cs == {2'b00, cs_expected});
                    run_sum   <= '0;
                    first_tag <= 1'b1;
                    in_cs     <= 1'b0;
                end
            end

            // Whatever follows the resync point is treated as a new message.
            if (err) begin
                tag_acc          <= '0;
                digit_cnt        <= '0;
                val_acc          <= '0;
                run_sum          <= '0;
                first_tag        <= 1'b1;
                in_cs            <= 1'b0;
                checksum_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fix_tokenizer.sv
// tb_fix_tokenizer
// Drives byte streams into fix_tokenizer and compares every emitted token,
// error pulse and checksum level against a field-level reference model.
module tb_fix_tokenizer;

    localparam int         VW   = 64;
    localparam int         MAXD = 9;
    localparam logic [7:0] SOH  = 8'h01;

    logic          clk = 1'b0;
    logic          rst;
    logic          byte_valid_i;
    logic [7:0]    byte_i;
    logic          byte_ready_o;
    logic          tag_valid_o;
    logic [31:0]   tag_o;
    logic          val_valid_o;
    logic [VW-1:0] val_o;
    logic          start_of_message_o;
    logic          end_of_message_o;
    logic          checksum_valid_o;
    logic          parse_error_o;

    fix_tokenizer #(.VALUE_WIDTH(VW), .MAX_TAG_DIGITS(MAXD)) dut (
        .clk                (clk),
        .rst                (rst),
        .byte_valid_i       (byte_valid_i),
        .byte_i             (byte_i),
        .byte_ready_o       (byte_ready_o),
        .tag_valid_o        (tag_valid_o),
        .tag_o              (tag_o),
        .val_valid_o        (val_valid_o),
        .val_o              (val_o),
        .start_of_message_o (start_of_message_o),
        .end_of_message_o   (end_of_message_o),
        .checksum_valid_o   (checksum_valid_o),
        .parse_error_o      (parse_error_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 tag, 1 value, 2 parse error
        logic [63:0] data;
        logic        som;
        logic        eom;
        logic        csv;
    } ev_t;

    ev_t        expq[$];
    logic [7:0] seg[$];
    logic [7:0] msum;
    logic       model_lvl;
    int n_cmp, n_bad;
    int n_tag, n_val, n_err, n_som, n_eom;

    function automatic bit is_dig(logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    function automatic void chk(string name, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h required %0h", name, obs, exp);
        end
    endfunction

    function automatic void push_byte(logic [7:0] b);
        seg.push_back(b);
        msum = msum + b;
    endfunction

    function automatic void add_str(string s);
        for (int i = 0; i < s.len(); i++)
            push_byte((s[i] == 8'h7C) ? SOH : s[i]);
    endfunction

    function automatic void start_msg();
        msum = 8'd0;
    endfunction

    // Appends "10=ccc|" where ccc is the message sum plus a deliberate offset.
    function automatic void finish_msg(int delta);
        int cs;
        cs = (int'(msum) + delta) % 256;
        seg.push_back(8'h31); seg.push_back(8'h30); seg.push_back(8'h3D);
        seg.push_back(8'(48 + cs / 100));
        seg.push_back(8'(48 + (cs / 10) % 10));
        seg.push_back(8'(48 + cs % 10));
        seg.push_back(SOH);
        msum = 8'd0;
    endfunction

    function automatic void exp_ev(int kind, logic [63:0] d, logic som, logic eom, logic csv);
        ev_t e;
        e.kind = kind; e.data = d; e.som = som; e.eom = eom; e.csv = csv;
        expq.push_back(e);
    endfunction

    // Field-by-field interpretation of the pending segment.
    function automatic void model_seg();
        int n, i, k, s, msg_start, num;
        bit first, ok;
        logic [31:0] tag;
        logic [7:0]  tsum;
        logic [63:0] val;
        n = seg.size(); i = 0; msg_start = 0; first = 1'b1;
        while (i < n) begin
            k = i;
            while (k < n && is_dig(seg[k]) && (k - i) < MAXD) k++;
            if (k >= n) break;
            if (seg[k] == 8'h3D && k > i) begin
                tag = 0; tsum = 0;
                for (int p = i; p < k; p++) tag = tag * 10 + 32'(int'(seg[p]) - 48);
                for (int p = msg_start; p < i; p++) tsum = tsum + seg[p];
                if (first) model_lvl = 1'b0;
                exp_ev(0, {32'd0, tag}, first, tag == 10, model_lvl);
                first = 1'b0;
                s = k + 1;
                while (s < n && seg[s] != SOH) s++;
                if (s >= n) break;
                val = 0;
                for (int p = k + 1; p < s; p++) val = {val[55:0], seg[p]};
                if (tag == 10) begin
                    ok = (s - k - 1) == 3;
                    num = 0;
                    for (int p = k + 1; p < s; p++) begin
                        if (!is_dig(seg[p])) ok = 1'b0;
                        else num = num * 10 + int'(seg[p]) - 48;
                    end
                    model_lvl = ok && (num == int'(tsum));
                    first = 1'b1;
                    msg_start = s + 1;
                end
                exp_ev(1, val, 1'b0, 1'b0, model_lvl);
                i = s + 1;
            end else begin
                model_lvl = 1'b0;
                exp_ev(2, 64'd0, 1'b0, 1'b0, 1'b0);
                s = k + 1;
                while (s < n && seg[s] != SOH) s++;
                if (s >= n) break;
                i = s + 1;
                first = 1'b1;
                msg_start = i;
            end
        end
    endfunction

    task automatic tick();
        ev_t e;
        int  kind;
        @(posedge clk);
        #1;
        chk("ready_rule", byte_ready_o, !(tag_valid_o || val_valid_o));
        if (tag_valid_o || val_valid_o || parse_error_o) begin
            kind = tag_valid_o ? 0 : (val_valid_o ? 1 : 2);
            chk("one_pulse", int'(tag_valid_o) + int'(val_valid_o) + int'(parse_error_o), 1);
            chk("event_expected", expq.size() != 0, 1);
            if (expq.size() != 0) begin
                e = expq.pop_front();
                chk("kind", kind, e.kind);
                if (kind == 0) begin
                    chk("tag", tag_o, e.data);
                    chk("som", start_of_message_o, e.som);
                    chk("eom", end_of_message_o, e.eom);
                end else if (kind == 1) begin
                    chk("val", val_o, e.data);
                end
                chk("csv", checksum_valid_o, e.csv);
            end
            if (tag_valid_o) n_tag++;
            if (val_valid_o) n_val++;
            if (parse_error_o) n_err++;
            if (start_of_message_o) n_som++;
            if (end_of_message_o) n_eom++;
        end else begin
            chk("idle_marks", {start_of_message_o, end_of_message_o}, 0);
        end
    endtask

    task automatic send_seg(bit toggle);
        bit acc;
        int guard;
        model_seg();
        foreach (seg[i]) begin
            if (toggle)
                for (int k = 0; k < 3 && $urandom_range(0, 1) == 1; k++) begin
                    byte_valid_i = 1'b0;
                    tick();
                end
            byte_valid_i = 1'b1;
            byte_i = seg[i];
            acc = 1'b0;
            guard = 0;
            while (!acc && guard < 50) begin
                acc = byte_ready_o;
                tick();
                guard++;
            end
            if (!acc) chk("ready_timeout", acc, 1);
        end
        byte_valid_i = 1'b0;
        seg.delete();
    endtask

    task automatic drain(int n);
        repeat (n) tick();
        chk("all_events_seen", expq.size(), 0);
        expq.delete();
    endtask

    task automatic clr_cnt();
        n_tag = 0; n_val = 0; n_err = 0; n_som = 0; n_eom = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        byte_valid_i = 1'b0;
        tick();
        tick();
        chk("rst_ready", byte_ready_o, 1);
        chk("rst_tag_valid", tag_valid_o, 0);
        chk("rst_val_valid", val_valid_o, 0);
        chk("rst_tag", tag_o, 0);
        chk("rst_val", val_o, 0);
        chk("rst_csv", checksum_valid_o, 0);
        chk("rst_err", parse_error_o, 0);
        rst = 1'b0;
        model_lvl = 1'b0;
        msum = 8'd0;
    endtask

    task automatic rand_msg();
        int nf, r, len;
        start_msg();
        add_str("8=FIX.4.4|");
        nf = $urandom_range(1, 4);
        for (int f = 0; f < nf; f++) begin
            r = $urandom_range(0, 11);
            if (r == 0)      add_str("7Z=xy|");
            else if (r == 1) add_str("1234567890=v|");
            else if (r == 2) add_str("=q|");
            else begin
                add_str($sformatf("%0d=", $urandom_range(11, 99999)));
                len = $urandom_range(0, 11);
                for (int c = 0; c < len; c++) push_byte(8'($urandom_range(32, 126)));
                push_byte(SOH);
            end
        end
        finish_msg(($urandom_range(0, 3) == 0) ? 1 : 0);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1'b1; byte_valid_i = 1'b0; byte_i = 8'h00;
        model_lvl = 1'b0; msum = 8'd0;
        clr_cnt();
        do_reset();

        // Reference message with a correct checksum, bytes back-to-back.
        clr_cnt(); start_msg();
        add_str("8=FIX.4.3|9=5|35=0|"); finish_msg(0);
        send_seg(1'b0); drain(4);
        chk("m1_csv", checksum_valid_o, 1);
        chk("m1_tags", n_tag, 4);
        chk("m1_vals", n_val, 4);
        chk("m1_som", n_som, 1);
        chk("m1_eom", n_eom, 1);
        chk("m1_err", n_err, 0);

        // Checksum off by one.
        clr_cnt(); start_msg();
        add_str("8=FIX.4.3|9=5|35=0|"); finish_msg(1);
        send_seg(1'b0); drain(4);
        chk("m2_csv", checksum_valid_o, 0);
        chk("m2_tags", n_tag, 4);
        chk("m2_vals", n_val, 4);

        // Bad tag, resync, then a clean message.
        clr_cnt();
        add_str("3X=junk|");
        start_msg();
        add_str("8=FIX.4.3|9=5|35=0|"); finish_msg(0);
        send_seg(1'b0); drain(4);
        chk("m3_err", n_err, 1);
        chk("m3_som", n_som, 1);
        chk("m3_csv", checksum_valid_o, 1);

        // Over-long value and zero-length value.
        clr_cnt(); start_msg();
        add_str("8=FIX.4.3|58=ABCDEFGHIJKL|59=|"); finish_msg(0);
        send_seg(1'b0); drain(4);
        chk("m4_vals", n_val, 4);
        chk("m4_err", n_err, 0);
        chk("m4_csv", checksum_valid_o, 1);

        // Two messages with byte_valid_i toggled.
        clr_cnt();
        start_msg(); add_str("8=FIX.4.3|9=5|35=0|"); finish_msg(1);
        start_msg(); add_str("8=FIX.4.3|9=5|35=0|"); finish_msg(0);
        send_seg(1'b1); drain(4);
        chk("m5_som", n_som, 2);
        chk("m5_eom", n_eom, 2);
        chk("m5_csv", checksum_valid_o, 1);

        // Reset in the middle of the tag-49 value.
        clr_cnt(); start_msg();
        add_str("8=FIX.4.3|49=SEND");
        send_seg(1'b0); drain(3);
        chk("m6_vals_before_rst", n_val, 1);
        chk("m6_tags_before_rst", n_tag, 2);
        do_reset();
        clr_cnt(); start_msg();
        add_str("8=FIX.4.3|9=5|35=0|"); finish_msg(0);
        send_seg(1'b0); drain(4);
        chk("m6_som", n_som, 1);
        chk("m6_csv", checksum_valid_o, 1);

        // Randomized messages, with occasional syntax errors and bad sums.
        for (int m = 0; m < 24; m++) begin
            rand_msg();
            send_seg($urandom_range(0, 1) == 1);
            drain(4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
